// File: rtl/alu_cmd_issuer.sv
// Initiator for the registered 8-bit ALU wrapper: issues tagged commands and returns tagged responses.
// Optional macro ALU_ISSUE_STATS_EN adds stat_issued/stat_zero counters with synchronous stat_clr.
module alu_cmd_issuer #(
  parameter int unsigned OP_W        = 3,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned CAPTURE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [3:0]        alu_flag,
  input  logic              alu_carry,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [3:0]        rsp_flag,
  output logic              rsp_carry,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
`ifdef ALU_ISSUE_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_zero
`endif
);

  if ((CAPTURE_LAT == 0) || (CAPTURE_LAT > 15)) begin : g_lat_chk
    $error("alu_cmd_issuer: CAPTURE_LAT=%0d outside 1..15", CAPTURE_LAT);
  end

  localparam logic [3:0] LAT = 4'(CAPTURE_LAT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic [TAG_W-1:0]   tag_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      tag_q      <= '0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
      rsp_flag   <= '0;
      rsp_carry  <= 1'b0;
      rsp_tag    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            alu_op    <= cmd_op;
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            tag_q     <= cmd_tag;
            cnt       <= 4'd1;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == LAT) begin
            rsp_result <= alu_result;
            rsp_flag   <= alu_flag;
            rsp_carry  <= alu_carry;
            rsp_tag    <= tag_q;
            rsp_valid  <= 1'b1;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_RESP: begin
          // cmd_ready stays low here, so a command offered alongside rsp_ready waits for IDLE
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ALU_ISSUE_STATS_EN
  logic accept_evt;
  logic zero_evt;

  always_comb begin
    accept_evt = (state == S_IDLE) && cmd_valid;
    zero_evt   = (state == S_WAIT) && (cnt == LAT) && alu_flag[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued <= '0;
      stat_zero   <= '0;
    end else if (stat_clr) begin
      stat_issued <= '0;
      stat_zero   <= '0;
    end else begin
      if (accept_evt) stat_issued <= stat_issued + 16'd1;
      if (zero_evt)   stat_zero   <= stat_zero + 16'd1;
    end
  end
`endif

endmodule
